// File: rtl/multicycle_alu.sv
// Clocked ALU with start/busy/done handshake and an iterative signed shift-add multiplier.
// Non-mul ops finish in one cycle; mul takes WIDTH+1 cycles and returns the full product on {HI, OUT}.
module multicycle_alu #(
  parameter int WIDTH      = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [WIDTH-1:0]      OP1,
  input  logic [WIDTH-1:0]      OP2,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  output logic [WIDTH-1:0]      OUT,
  output logic [WIDTH-1:0]      HI,
  output logic                  ZERO,
  output logic                  INVALID,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH:0]     r_acc;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_out;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_zero;
  logic                 r_inv;
  logic                 r_done;

  logic                 w_shamt_big;
  logic [WIDTH-1:0]     w_alu_out;
  logic                 w_alu_inv;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_acc_step;
  logic [2*WIDTH-1:0]   w_prod;

  // WIDTH is a power of two, so any set bit above the low SHW bits means amount >= WIDTH.
  assign w_shamt_big = |OP2[WIDTH-1:SHW];

  always_comb begin
    w_alu_out = '0;
    w_alu_inv = 1'b0;
    case (OPRN)
      OP_ADD: w_alu_out = OP1 + OP2;
      OP_SUB: w_alu_out = OP1 - OP2;
      OP_MUL: w_alu_out = '0;
      OP_SRL: w_alu_out = w_shamt_big ? '0 : (OP1 >> OP2[SHW-1:0]);
      OP_SLL: w_alu_out = w_shamt_big ? '0 : (OP1 << OP2[SHW-1:0]);
      OP_AND: w_alu_out = OP1 & OP2;
      OP_OR:  w_alu_out = OP1 | OP2;
      OP_NOR: w_alu_out = ~(OP1 | OP2);
      OP_SLT: w_alu_out = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      default: w_alu_inv = 1'b1;
    endcase
  end

  // Unsigned magnitudes fit WIDTH bits even for the most-negative operand.
  assign w_mag1 = OP1[WIDTH-1] ? ('0 - OP1) : OP1;
  assign w_mag2 = OP2[WIDTH-1] ? ('0 - OP2) : OP2;

  // Accumulator: upper WIDTH+1 bits collect partial sums, lower WIDTH bits shift out the multiplier.
  assign w_addend   = r_acc[0] ? r_mcand : '0;
  assign w_sum      = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_acc_step = {1'b0, w_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg ? ('0 - r_acc[2*WIDTH-1:0]) : r_acc[2*WIDTH-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving MUL on the step that takes the counter from 1 to 0 puts the last step at edge k+WIDTH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START && (OPRN == OP_MUL)) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == CW'(1)) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_out   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b1;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            if (OPRN == OP_MUL) begin
              r_mcand <= w_mag1;
              r_acc   <= {{(WIDTH+1){1'b0}}, w_mag2};
              r_neg   <= OP1[WIDTH-1] ^ OP2[WIDTH-1];
              r_cnt   <= CW'(WIDTH);
            end else begin
              r_out  <= w_alu_out;
              r_hi   <= '0;
              r_zero <= (w_alu_out == '0);
              r_inv  <= w_alu_inv;
              r_done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIN: begin
          r_hi   <= w_prod[2*WIDTH-1:WIDTH];
          r_out  <= w_prod[WIDTH-1:0];
          r_zero <= (w_prod[WIDTH-1:0] == '0);
          r_inv  <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign OUT     = r_out;
  assign HI      = r_hi;
  assign ZERO    = r_zero;
  assign INVALID = r_inv;
  assign BUSY    = (r_state != S_IDLE);
  assign DONE    = r_done;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized checks of multicycle_alu (WIDTH=32) against an arithmetic reference model.
module tb_multicycle_alu;

  localparam int W  = 32;
  localparam int OW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [W-1:0]  OP1;
  logic [W-1:0]  OP2;
  logic [OW-1:0] OPRN;
  logic [W-1:0]  OUT;
  logic [W-1:0]  HI;
  logic          ZERO;
  logic          INVALID;
  logic          BUSY;
  logic          DONE;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(W), .OPRN_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP1(OP1), .OP2(OP2), .OPRN(OPRN),
    .OUT(OUT), .HI(HI), .ZERO(ZERO), .INVALID(INVALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain arithmetic on the opcode map, 64-bit signed product for mul.
  function automatic void model(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] o, output logic [W-1:0] h, output logic inv);
    longint p;
    o = '0; h = '0; inv = 1'b0;
    case (op)
      6'h1: o = a + b;
      6'h2: o = a - b;
      6'h3: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        o = p[31:0];
        h = p[63:32];
      end
      6'h4: o = (b >= 32'd32) ? '0 : (a >> b);
      6'h5: o = (b >= 32'd32) ? '0 : (a << b);
      6'h6: o = a & b;
      6'h7: o = a | b;
      6'h8: o = ~(a | b);
      6'h9: o = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      default: inv = 1'b1;
    endcase
  endfunction

  task automatic issue(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    OPRN = op; OP1 = a; OP2 = b; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eo, eh;
    logic         ei;
    model(op, a, b, eo, eh, ei);
    chk($sformatf("%s DONE", tag), {31'b0, DONE}, 32'd1);
    chk($sformatf("%s BUSY", tag), {31'b0, BUSY}, 32'd0);
    chk($sformatf("%s OUT", tag), OUT, eo);
    chk($sformatf("%s HI", tag), HI, eh);
    chk($sformatf("%s ZERO", tag), {31'b0, ZERO}, {31'b0, (eo == '0)});
    chk($sformatf("%s INVALID", tag), {31'b0, INVALID}, {31'b0, ei});
  endtask

  task automatic nonmul(input string tag, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    expect_done(tag, op, a, b);
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk($sformatf("%s DONE drop", tag), {31'b0, DONE}, 32'd0);
  endtask

  // Runs a mul; optionally fires an add START mid-multiply, which must be ignored.
  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    int lat  = 0;
    int busy = 0;
    issue(6'h3, a, b);
    chk($sformatf("%s BUSY after accept", tag), {31'b0, BUSY}, 32'd1);
    if (BUSY) busy++;
    OP1 = ~a; OP2 = a ^ b; OPRN = 6'h1;
    for (int n = 1; n <= 60; n++) begin
      if (disturb && n == 6) begin
        START = 1'b1; OPRN = 6'h1; OP1 = 32'd2; OP2 = 32'd3;
      end
      tick();
      START = 1'b0;
      if (DONE) begin
        lat = n;
        break;
      end
      if (n < W && BUSY) busy++;
    end
    chk($sformatf("%s latency", tag), lat, W + 1);
    chk($sformatf("%s busy cycles", tag), busy, W);
    expect_done(tag, 6'h3, a, b);
  endtask

  initial begin
    logic [OW-1:0] ops[12] = '{6'h1, 6'h2, 6'h3, 6'h4, 6'h5, 6'h6, 6'h7, 6'h8, 6'h9, 6'h0, 6'hA, 6'h3F};
    logic [OW-1:0] op;
    logic [W-1:0]  a, b;
    bit            seen;

    RST = 1'b1; START = 1'b0; OP1 = '0; OP2 = '0; OPRN = '0;
    #3 RST = 1'b0;
    #1;
    chk("reset OUT", OUT, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset ZERO", {31'b0, ZERO}, 32'd1);
    chk("reset INVALID", {31'b0, INVALID}, 32'd0);
    chk("reset BUSY", {31'b0, BUSY}, 32'd0);
    chk("reset DONE", {31'b0, DONE}, 32'd0);
    tick(); tick();
    #2 RST = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("post-reset");

    nonmul("add ovf", 6'h1, 32'h7FFFFFFF, 32'h1);
    idle_check("add ovf");
    nonmul("sub eq", 6'h2, 32'd5, 32'd5);
    nonmul("nor zero", 6'h8, 32'd0, 32'd0);
    nonmul("sll 31", 6'h5, 32'h1, 32'd31);
    nonmul("sll 32", 6'h5, 32'h1, 32'd32);
    nonmul("srl 4", 6'h4, 32'h80000000, 32'd4);
    nonmul("slt -1<1", 6'h9, 32'hFFFFFFFF, 32'd1);
    nonmul("slt 1<-1", 6'h9, 32'd1, 32'hFFFFFFFF);
    nonmul("invalid 3F", 6'h3F, 32'h1234, 32'h5678);
    idle_check("invalid 3F");

    mul("mul -3x7", 32'hFFFFFFFD, 32'd7, 1'b0);
    nonmul("start in DONE cycle", 6'h7, 32'hF0F0_0000, 32'h0000_0F0F);
    idle_check("after back-to-back");
    mul("mul minneg sq", 32'h80000000, 32'h80000000, 1'b0);
    idle_check("mul minneg sq");
    mul("mul ignore busy START", 32'h0001_2345, 32'hFFFF_FF00, 1'b1);
    idle_check("no queued START");

    nonmul("pre-abort", 6'h1, 32'd40, 32'd2);
    issue(6'h3, 32'd1234, 32'd5678);
    repeat (10) tick();
    #2 RST = 1'b0;
    #1;
    chk("abort BUSY", {31'b0, BUSY}, 32'd0);
    chk("abort OUT", OUT, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort DONE", {31'b0, DONE}, 32'd0);
    #2 RST = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE) seen = 1'b1;
    end
    chk("abort no DONE", {31'b0, seen}, 32'd0);
    mul("mul after abort", 32'hFFFF_FFF9, 32'hFFFF_FFFB, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      a  = $urandom;
      b  = $urandom;
      if ((op == 6'h4 || op == 6'h5) && $urandom_range(0, 1) == 1) b = $urandom_range(0, 40);
      if (op == 6'h3) mul($sformatf("rand%0d mul", i), a, b, 1'b0);
      else nonmul($sformatf("rand%0d op%0h", i, op), op, a, b);
    end
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
